// File: rtl/rs232_arb_pkg.sv
// Shared types and constants for the RS232 transmit arbiter.
// Holds the arbiter state encoding and the header tag base value.
package rs232_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    PASS   = 2'd2
  } state_e;

  // Header byte is HEADER_TAG | grantee index; the host demuxes streams by it
  localparam logic [7:0] HEADER_TAG = 8'h80;

endpackage

// File: rtl/rs232_tx_arbiter_if.sv
// Requester-side AXI-stream bytes plus the shared output stream and grant status.
// slave = arbiter side, master = requesters/transmit-buffer side.
interface rs232_tx_arbiter_if #(
  parameter int PORTS = 4
);
  localparam int GW = $clog2(PORTS);

  logic [8*PORTS-1:0] idata;
  logic [PORTS-1:0]   ivalid;
  logic [PORTS-1:0]   ilast;
  logic [PORTS-1:0]   iready;
  logic [7:0]         odata;
  logic               ovalid;
  logic               olast;
  logic               oready;
  logic [GW-1:0]      ogrant;
  logic               obusy;

  modport slave (
    input  idata, ivalid, ilast, oready,
    output iready, odata, ovalid, olast, ogrant, obusy
  );

  modport master (
    output idata, ivalid, ilast, oready,
    input  iready, odata, ovalid, olast, ogrant, obusy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// Zero latency; no handshake of its own.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);

  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic [N-1:0] win;
  logic [PW:0]  off;
  logic [PW:0]  sum;

  always_comb begin
    // Doubled vector shifted by the pointer puts the wrap-around candidates in order
    win     = N'({req_i, req_i} >> ptr_i);
    found_o = 1'b0;
    off     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (win[i]) begin
        found_o = 1'b1;
        off     = (PW+1)'(i);
      end
    end
    sum   = {1'b0, ptr_i} + off;
    idx_o = (sum >= N_W) ? PW'(sum - N_W) : PW'(sum);
  end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin, packet-atomic, burst-limited arbiter onto one byte stream; RS232_TX_ARBITER_HEADER_EN adds a tag byte per grant.
// Zero-cycle data path, one bubble per grant; oready is mirrored only to the grantee's iready.
module rs232_tx_arbiter
  import rs232_arb_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int MAX_BURST = 16
) (
  input logic               clock,
  input logic               resetn,
  rs232_tx_arbiter_if.slave bus
);

  localparam int GW = $clog2(PORTS);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [GW-1:0] LAST_PORT = GW'(PORTS - 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
`ifdef RS232_TX_ARBITER_HEADER_EN
  localparam state_e GRANT_ENTRY = HEADER;
`else
  localparam state_e GRANT_ENTRY = PASS;
`endif

  state_e         state_q, state_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [GW-1:0]  pick_idx;
  logic           pick_found;
  logic [7:0]     sel_dat;
  logic           sel_vld;
  logic           sel_lst;
  logic [7:0]     odata;
  logic           ovalid;
  logic           olast;
  logic [PORTS-1:0] iready;

  rr_pick #(.N(PORTS)) u_pick (
    .req_i   (bus.ivalid),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    sel_dat = '0;
    sel_vld = 1'b0;
    sel_lst = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      if (grant_q == GW'(k)) begin
        sel_dat = bus.idata[8*k +: 8];
        sel_vld = bus.ivalid[k];
        sel_lst = bus.ilast[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    odata   = '0;
    ovalid  = 1'b0;
    olast   = 1'b0;
    iready  = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT_ENTRY;
        end
      end
`ifdef RS232_TX_ARBITER_HEADER_EN
      HEADER: begin
        odata  = HEADER_TAG | {{(8-GW){1'b0}}, grant_q};
        ovalid = 1'b1;
        if (bus.oready) state_d = PASS;
      end
`endif
      PASS: begin
        odata  = sel_dat;
        ovalid = sel_vld;
        olast  = sel_vld & sel_lst;
        for (int k = 0; k < PORTS; k++) begin
          iready[k] = bus.oready && (grant_q == GW'(k));
        end
        if (sel_vld && bus.oready) begin
          cnt_d = cnt_q + 1'b1;
          // Counter tops out at MAX_BURST because that beat always releases
          if (sel_lst || cnt_d == BURST_MAX) begin
            state_d = IDLE;
            ptr_d   = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.odata  = odata;
  assign bus.ovalid = ovalid;
  assign bus.olast  = olast;
  assign bus.iready = iready;
  assign bus.ogrant = grant_q;
  assign bus.obusy  = (state_q != IDLE);

endmodule
